// File: rtl/mem_access_unit_if.sv
// Request/completion and BRAM port bundle for the data-memory responder.
// slave = the responder itself; master = sequencer plus BRAM side.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  req;
  logic                  req_we;
  logic [31:0]           req_addr;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_wdata;
  logic                  busy;
  logic                  done;
  logic                  misaligned;
  logic [31:0]           rdata;
  logic                  bram_en;
  logic [3:0]            bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [31:0]           bram_wdata;
  logic [31:0]           bram_rdata;

  modport slave (
    input  req, req_we, req_addr, req_size, req_unsigned, req_wdata, bram_rdata,
    output busy, done, misaligned, rdata, bram_en, bram_we, bram_addr, bram_wdata
  );

  modport master (
    output req, req_we, req_addr, req_size, req_unsigned, req_wdata, bram_rdata,
    input  busy, done, misaligned, rdata, bram_en, bram_we, bram_addr, bram_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory responder: one load/store at a time against a synchronous BRAM.
// Latency store 2, load 2+READ_LATENCY, misaligned 1; requests arriving while busy are dropped.
module mem_access_unit #(
  parameter int ADDR_WIDTH   = 14,
  parameter int READ_LATENCY = 2
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;

  localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic                  uns_q, uns_d;
  logic                  mis_q, mis_d;
  logic [1:0]            size_q, size_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  bram_en_q, bram_en_d;
  logic [3:0]            bram_we_q, bram_we_d;
  logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
  logic [31:0]           bram_wdata_q, bram_wdata_d;

  logic                  req_mis;
  logic [3:0]            st_we;
  logic [31:0]           st_wdata;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           ld_val;

  // Store lanes and alignment are decided straight from the request so the
  // registered BRAM strobes are already valid in the ACCESS cycle.
  always_comb begin
    req_mis  = 1'b0;
    st_we    = 4'b1111;
    st_wdata = bus.req_wdata;
    unique case (bus.req_size)
      2'd0: begin
        st_we    = 4'b0001 << bus.req_addr[1:0];
        st_wdata = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        req_mis  = bus.req_addr[0];
        st_we    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{bus.req_wdata[15:0]}};
      end
      default: req_mis = (bus.req_addr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    rd_byte = bus.bram_rdata[{off_q, 3'b000} +: 8];
    rd_half = off_q[1] ? bus.bram_rdata[31:16] : bus.bram_rdata[15:0];
    unique case (size_q)
      2'd0:    ld_val = {{24{~uns_q & rd_byte[7]}}, rd_byte};
      2'd1:    ld_val = {{16{~uns_q & rd_half[15]}}, rd_half};
      default: ld_val = bus.bram_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    uns_d        = uns_q;
    mis_d        = mis_q;
    size_d       = size_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    bram_en_d    = 1'b0;
    bram_we_d    = 4'b0000;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          we_d   = bus.req_we;
          uns_d  = bus.req_unsigned;
          size_d = bus.req_size;
          off_d  = bus.req_addr[1:0];
          mis_d  = req_mis;
          if (req_mis) begin
            state_d = DONE;
          end else begin
            state_d     = ACCESS;
            bram_en_d   = 1'b1;
            bram_addr_d = bus.req_addr[ADDR_WIDTH+1:2];
            if (bus.req_we) begin
              bram_we_d    = st_we;
              bram_wdata_d = st_wdata;
            end
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          rdata_d = ld_val;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      mis_q        <= 1'b0;
      size_q       <= 2'd0;
      off_q        <= 2'd0;
      cnt_q        <= 3'd0;
      rdata_q      <= 32'd0;
      bram_en_q    <= 1'b0;
      bram_we_q    <= 4'b0000;
      bram_addr_q  <= '0;
      bram_wdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      uns_q        <= uns_d;
      mis_q        <= mis_d;
      size_q       <= size_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      bram_en_q    <= bram_en_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.misaligned = (state_q == DONE) && mis_q;
  assign bus.rdata      = rdata_q;
  assign bus.bram_en    = bram_en_q;
  assign bus.bram_we    = bram_we_q;
  assign bus.bram_addr  = bram_addr_q;
  assign bus.bram_wdata = bram_wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (READ_LATENCY 2 and 1), each with a BRAM model,
// driven by directed and random requests and compared every cycle against a transaction model.
module tb_mem_access_unit;
  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;
  localparam int NI    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_v [NI];
  logic        req_v [NI];
  logic        we_v  [NI];
  logic [31:0] addr_v[NI];
  logic [1:0]  size_v[NI];
  logic        uns_v [NI];
  logic [31:0] wd_v  [NI];

  logic          busy_o[NI], done_o[NI], mis_o[NI], en_o[NI];
  logic [31:0]   rdata_o[NI], bwd_o[NI];
  logic [3:0]    bwe_o[NI];
  logic [AW-1:0] badr_o[NI];

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int RL = (g == 0) ? 2 : 1;
    mem_access_unit_if #(.ADDR_WIDTH(AW)) bus ();
    mem_access_unit #(.ADDR_WIDTH(AW), .READ_LATENCY(RL)) u_dut (
      .clk  (clk),
      .reset(rst_v[g]),
      .bus  (bus)
    );
    assign bus.req          = req_v[g];
    assign bus.req_we       = we_v[g];
    assign bus.req_addr     = addr_v[g];
    assign bus.req_size     = size_v[g];
    assign bus.req_unsigned = uns_v[g];
    assign bus.req_wdata    = wd_v[g];
    assign busy_o[g]  = bus.busy;
    assign done_o[g]  = bus.done;
    assign mis_o[g]   = bus.misaligned;
    assign rdata_o[g] = bus.rdata;
    assign en_o[g]    = bus.bram_en;
    assign bwe_o[g]   = bus.bram_we;
    assign badr_o[g]  = bus.bram_addr;
    assign bwd_o[g]   = bus.bram_wdata;

    logic [31:0] mem [DEPTH] = '{default: 32'd0};
    logic [31:0] pipe [RL];
    // Random data on idle cycles exposes a capture at the wrong latency.
    always @(posedge clk) begin
      pipe[0] <= bus.bram_en ? mem[bus.bram_addr] : $urandom;
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
      if (bus.bram_en)
        for (int b = 0; b < 4; b++)
          if (bus.bram_we[b]) mem[bus.bram_addr][8*b +: 8] <= bus.bram_wdata[8*b +: 8];
    end
    assign bus.bram_rdata = pipe[RL-1];
  end

  // Transaction model
  int            rl_m [NI] = '{2, 1};
  logic [31:0]   ref_mem [NI][DEPTH];
  bit            pend [NI];
  int            t0_m [NI], tdone_m [NI], nb_m [NI], off_m [NI], last_done [NI];
  bit            mis_m [NI], we_m [NI], uns_m [NI];
  logic [AW-1:0] wa_m [NI], last_addr [NI];
  logic [31:0]   wd_m [NI], exp_rdata [NI];
  int            checks = 0, passed = 0;
  bit            chk_en = 1'b0;

  function automatic logic [3:0] lanes_of(int off, int nb);
    logic [3:0] l = 4'b0000;
    for (int b = 0; b < 4; b++) if (b >= off && b < off + nb) l[b] = 1'b1;
    return l;
  endfunction

  function automatic logic [31:0] wdata_of(logic [31:0] wd, int nb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ext(logic [31:0] word, int off, int nb, bit u);
    logic [31:0] v = word >> (8 * off);
    logic [31:0] m;
    if (nb < 4) begin
      m = (32'h1 << (8 * nb)) - 32'h1;
      v = v & m;
      if (!u && v[8*nb-1]) v = v | ~m;
    end
    return v;
  endfunction

  task automatic chk(string nm, int g, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s inst%0d cyc%0d: got 0x%08h expected 0x%08h", nm, g, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    bit          busy_e, done_e, en_e;
    logic [3:0]  we_e;
    logic [31:0] wdat_e;
    if (chk_en) begin
      for (int g = 0; g < NI; g++) begin
        busy_e = pend[g] && cyc > t0_m[g] && cyc <= tdone_m[g];
        done_e = pend[g] && cyc == tdone_m[g];
        en_e   = pend[g] && !mis_m[g] && cyc == t0_m[g] + 1;
        we_e   = 4'b0000;
        wdat_e = 32'd0;
        if (en_e) begin
          last_addr[g] = wa_m[g];
          if (we_m[g]) begin
            we_e   = lanes_of(off_m[g], nb_m[g]);
            wdat_e = wdata_of(wd_m[g], nb_m[g]);
            for (int b = 0; b < 4; b++)
              if (we_e[b]) ref_mem[g][wa_m[g]][8*b +: 8] = wdat_e[8*b +: 8];
          end
        end
        if (done_e && !mis_m[g] && !we_m[g])
          exp_rdata[g] = ext(ref_mem[g][wa_m[g]], off_m[g], nb_m[g], uns_m[g]);
        chk("busy", g, busy_o[g], busy_e);
        chk("done", g, done_o[g], done_e);
        chk("misaligned", g, mis_o[g], done_e && mis_m[g]);
        chk("rdata", g, rdata_o[g], exp_rdata[g]);
        chk("bram_en", g, en_o[g], en_e);
        chk("bram_we", g, bwe_o[g], we_e);
        chk("bram_addr", g, badr_o[g], last_addr[g]);
        if (en_e && we_m[g]) chk("bram_wdata", g, bwd_o[g], wdat_e);
        if (done_o[g]) last_done[g] = cyc;
        if (done_e) pend[g] = 1'b0;
        if (rst_v[g]) begin
          pend[g] = 1'b0;
          exp_rdata[g] = 32'd0;
          last_addr[g] = '0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int g, bit we, logic [31:0] a, logic [1:0] sz, bit u, logic [31:0] wd);
    int nb;
    req_v[g] = 1'b1; we_v[g] = we; addr_v[g] = a; size_v[g] = sz; uns_v[g] = u; wd_v[g] = wd;
    if (!pend[g]) begin
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      pend[g]  = 1'b1;
      t0_m[g]  = cyc;
      nb_m[g]  = nb;
      off_m[g] = int'(a[1:0]);
      mis_m[g] = (off_m[g] % nb) != 0;
      we_m[g]  = we;
      uns_m[g] = u;
      wa_m[g]  = a[AW+1:2];
      wd_m[g]  = wd;
      tdone_m[g] = cyc + (mis_m[g] ? 1 : we ? 2 : 2 + rl_m[g]);
    end
    tick();
    req_v[g] = 1'b0;
    we_v[g] = 1'($urandom); addr_v[g] = $urandom; size_v[g] = 2'($urandom);
    uns_v[g] = 1'($urandom); wd_v[g] = $urandom;
  endtask

  task automatic wait_idle(int g);
    int n = 0;
    while (pend[g] && n < 40) begin
      tick();
      n++;
    end
    if (pend[g]) begin
      checks++;
      $display("FAIL timeout inst%0d cyc%0d: still pending, expected done", g, cyc);
      pend[g] = 1'b0;
    end
  endtask

  task automatic pulse_reset(int g);
    rst_v[g] = 1'b1;
    tick();
    rst_v[g] = 1'b0;
  endtask

  logic [31:0] sub_exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F1, 32'h00007F02};
  logic [31:0] sub_adr [4] = '{32'h203, 32'h203, 32'h202, 32'h200};
  logic [1:0]  sub_sz  [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
  bit          sub_u   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    for (int g = 0; g < NI; g++) begin
      rst_v[g] = 1'b1; req_v[g] = 1'b0; we_v[g] = 1'b0; addr_v[g] = 32'd0;
      size_v[g] = 2'd0; uns_v[g] = 1'b0; wd_v[g] = 32'd0;
      pend[g] = 1'b0; exp_rdata[g] = 32'd0; last_addr[g] = '0; last_done[g] = -1;
      t0_m[g] = 0; tdone_m[g] = 0;
      for (int i = 0; i < DEPTH; i++) ref_mem[g][i] = 32'd0;
    end
    repeat (3) tick();
    chk_en = 1'b1;
    tick();
    for (int g = 0; g < NI; g++) rst_v[g] = 1'b0;

    // Word store then load
    send(0, 1, 32'h100, 2'd2, 0, 32'hDEADBEEF);
    chk("sw_we", 0, bwe_o[0], 32'hF);
    chk("sw_addr", 0, badr_o[0], 32'h40);
    wait_idle(0);
    chk("sw_latency", 0, last_done[0] - t0_m[0], 2);
    send(0, 0, 32'h100, 2'd2, 0, 32'd0);
    wait_idle(0);
    chk("lw_rdata", 0, rdata_o[0], 32'hDEADBEEF);
    chk("lw_model", 0, exp_rdata[0], 32'hDEADBEEF);
    chk("lw_latency", 0, last_done[0] - t0_m[0], 4);

    // Sub-word loads
    send(0, 1, 32'h200, 2'd2, 0, 32'h80F17F02);
    wait_idle(0);
    for (int k = 0; k < 4; k++) begin
      send(0, 0, sub_adr[k], sub_sz[k], sub_u[k], 32'd0);
      wait_idle(0);
      chk("subword_rdata", 0, rdata_o[0], sub_exp[k]);
    end

    // Byte store into a known word
    send(0, 1, 32'h300, 2'd2, 0, 32'h11223344);
    wait_idle(0);
    send(0, 1, 32'h301, 2'd0, 0, 32'h000000AB);
    chk("sb_we", 0, bwe_o[0], 32'h2);
    chk("sb_wdata", 0, bwd_o[0], 32'hABABABAB);
    wait_idle(0);
    send(0, 0, 32'h300, 2'd2, 0, 32'd0);
    wait_idle(0);
    chk("sb_readback", 0, rdata_o[0], 32'h1122AB44);

    // Misaligned word load
    send(0, 0, 32'h102, 2'd2, 0, 32'd0);
    chk("mis_done", 0, done_o[0], 1);
    chk("mis_flag", 0, mis_o[0], 1);
    chk("mis_en", 0, en_o[0], 0);
    wait_idle(0);
    chk("mis_rdata_held", 0, rdata_o[0], 32'h1122AB44);

    // Request while busy is dropped
    send(0, 0, 32'h100, 2'd2, 0, 32'd0);
    tick();
    send(0, 0, 32'h200, 2'd2, 0, 32'd0);
    wait_idle(0);
    chk("busy_req_latency", 0, last_done[0] - t0_m[0], 4);
    chk("busy_req_rdata", 0, rdata_o[0], 32'hDEADBEEF);

    // Reset mid-load, then a normal load
    send(0, 0, 32'h100, 2'd2, 0, 32'd0);
    tick();
    pulse_reset(0);
    chk("rst_busy", 0, busy_o[0], 0);
    chk("rst_rdata", 0, rdata_o[0], 0);
    chk("rst_done", 0, done_o[0], 0);
    repeat (4) tick();
    send(0, 0, 32'h200, 2'd2, 0, 32'd0);
    wait_idle(0);
    chk("post_rst_rdata", 0, rdata_o[0], 32'h80F17F02);
    chk("post_rst_latency", 0, last_done[0] - t0_m[0], 4);

    // READ_LATENCY = 1 instance
    send(1, 1, 32'h40, 2'd2, 0, 32'hCAFEF00D);
    wait_idle(1);
    send(1, 0, 32'h42, 2'd1, 0, 32'd0);
    wait_idle(1);
    chk("rl1_lh", 1, rdata_o[1], 32'hFFFFCAFE);
    chk("rl1_latency", 1, last_done[1] - t0_m[1], 3);
    send(1, 0, 32'h40, 2'd2, 0, 32'd0);
    tick();
    pulse_reset(1);
    chk("rl1_rst_busy", 1, busy_o[1], 0);
    chk("rl1_rst_rdata", 1, rdata_o[1], 0);
    send(1, 0, 32'h43, 2'd0, 1, 32'd0);
    wait_idle(1);
    chk("rl1_lbu", 1, rdata_o[1], 32'h000000CA);
    chk("rl1_post_rst_latency", 1, last_done[1] - t0_m[1], 3);

    // Random traffic on a few words with random upper address bits (wrap)
    for (int g = 0; g < NI; g++) begin
      for (int n = 0; n < 250; n++) begin
        send(g, 1'($urandom), ($urandom & 32'hFFFF0000) | 32'($urandom_range(0, 63)),
             2'($urandom), 1'($urandom), $urandom);
        if ($urandom_range(0, 4) == 0) begin
          repeat ($urandom_range(0, 2)) tick();
          send(g, 1'($urandom), $urandom, 2'($urandom), 1'($urandom), $urandom);
        end
        if ($urandom_range(0, 29) == 0) pulse_reset(g);
        wait_idle(g);
        repeat ($urandom_range(0, 1)) tick();
      end
    end

    tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
